// File: rtl/penc_pkg.sv
// penc_pkg: shared constants and helpers for the registered priority encoder.
package penc_pkg;
  localparam int PENC_N_MAX = 64;
  function automatic logic [PENC_N_MAX-1:0] onehot(input logic [5:0] idx);
    return PENC_N_MAX'(1) << idx;
  endfunction
  // Rotates the low n bits of v down by sh (sh < n); bit k of the result is v[(k+sh) mod n].
  function automatic logic [PENC_N_MAX-1:0] rot_down(input logic [PENC_N_MAX-1:0] v, input logic [5:0] sh, input int n);
    logic [PENC_N_MAX-1:0] m;
    logic [2*PENC_N_MAX-1:0] d;
    m = (n >= PENC_N_MAX) ? '1 : ((PENC_N_MAX'(1) << n) - PENC_N_MAX'(1));
    d = {PENC_N_MAX'(0), v & m} | ({PENC_N_MAX'(0), v & m} << n);
    return PENC_N_MAX'(d >> sh) & m;
  endfunction
endpackage

// File: rtl/priority_encoder_rr_prio_search.sv
// prio_search: picks the first set bit searching downward from i_start-1, wrapping to N-1.
import penc_pkg::*;
module prio_search #(
  parameter int N = 8
) (
  input  logic [N-1:0]         i_vec,
  input  logic [$clog2(N)-1:0] i_start,
  output logic [$clog2(N)-1:0] o_idx,
  output logic                 o_found
);
  localparam int W = $clog2(N);
  logic [N-1:0] w_rot;
  logic [W-1:0] w_j;
  logic [W:0]   w_sum;
  assign w_rot = N'(rot_down(PENC_N_MAX'(i_vec), 6'(i_start), N));
  always_comb begin
    w_j = '0;
    for (int k = 0; k < N; k++) w_j = w_rot[k] ? W'(k) : w_j;
  end
  assign w_sum   = {1'b0, w_j} + {1'b0, i_start};
  assign o_idx   = (w_sum >= (W+1)'(N)) ? W'(w_sum - (W+1)'(N)) : W'(w_sum);
  assign o_found = |i_vec;
endmodule

// File: rtl/priority_encoder_rr.sv
// priority_encoder_rr: sticky-request priority encoder with valid/ready output.
// Define PRIO_ENC_RR_EN for round-robin rotation; otherwise highest index wins.
import penc_pkg::*;
module priority_encoder_rr #(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_onehot,
  output logic         busy
);
  logic [N-1:0] r_pend;
  logic         r_valid;
  logic [W-1:0] r_idx;
  logic [N-1:0] w_eff;
  logic         w_free;
  logic         w_load;
  logic         w_found;
  logic [W-1:0] w_win;
  logic [W-1:0] w_start;
  assign w_eff  = r_pend | req;
  assign w_free = !r_valid || out_ready;
  assign w_load = w_free && w_found;
`ifdef PRIO_ENC_RR_EN
  logic [W-1:0] r_ptr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_ptr <= '0;
    else if (w_load) r_ptr <= w_win;
  assign w_start = r_ptr;
`else
  assign w_start = '0;
`endif
  prio_search #(.N(N)) u_search (
    .i_vec   (w_eff),
    .i_start (w_start),
    .o_idx   (w_win),
    .o_found (w_found)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_pend  <= '0;
      r_valid <= 1'b0;
      r_idx   <= '0;
    end else begin
      r_pend  <= w_load ? (w_eff & ~N'(onehot(6'(w_win)))) : w_eff;
      r_valid <= w_free ? w_found : r_valid;
      r_idx   <= w_load ? w_win : r_idx;
    end
  assign out_valid  = r_valid;
  assign out_idx    = r_idx;
  assign out_onehot = r_valid ? N'(onehot(6'(r_idx))) : '0;
  assign busy       = |r_pend || r_valid;
endmodule

// File: tb/tb_priority_encoder_rr.sv
// tb_priority_encoder_rr: directed and random stimulus against a search-order reference model.
module tb_priority_encoder_rr;
  localparam int N = 8;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic         out_ready = 1'b0;
  logic         out_valid;
  logic [2:0]   out_idx;
  logic [N-1:0] out_onehot;
  logic         busy;
  int n_checks = 0;
  int n_fail = 0;
  logic [N-1:0] m_pend = '0;
  logic         m_valid = 1'b0;
  int           m_idx = 0;
  int           m_ptr = 0;

  priority_encoder_rr #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_idx    (out_idx),
    .out_onehot (out_onehot),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Search order from the last issued index: ptr-1, ptr-2, ..., wrapping round to ptr.
  function automatic int pick(input logic [N-1:0] e, input int p);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (p - k + N) % N;
      if (e[c]) return c;
    end
    return -1;
  endfunction

  task automatic chk_all(input string tag);
    logic [N-1:0] oh;
    oh = m_valid ? N'(1) << m_idx : '0;
    chk({tag, ".valid"}, 64'(out_valid), 64'(m_valid));
    chk({tag, ".busy"}, 64'(busy), 64'(m_valid || (m_pend != 0)));
    chk({tag, ".onehot"}, 64'(out_onehot), 64'(oh));
    if (m_valid) chk({tag, ".idx"}, 64'(out_idx), 64'(m_idx));
  endtask

  task automatic step(input logic [N-1:0] r, input logic rdy, input string tag);
    logic [N-1:0] eff;
    int w;
    req = r;
    out_ready = rdy;
    eff = m_pend | r;
    if (!m_valid || rdy) begin
      w = pick(eff, m_ptr);
      if (w >= 0) begin
        m_valid = 1'b1;
        m_idx = w;
        m_pend = eff & ~(N'(1) << w);
`ifdef PRIO_ENC_RR_EN
        m_ptr = w;
`endif
      end else begin
        m_valid = 1'b0;
        m_pend = eff;
      end
    end else m_pend = eff;
    @(posedge clk);
    #1;
    chk_all(tag);
  endtask

  task automatic model_reset();
    m_pend = '0;
    m_valid = 1'b0;
    m_idx = 0;
    m_ptr = 0;
  endtask

  initial begin
    req = '1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.valid", 64'(out_valid), 64'(0));
    chk("rst.busy", 64'(busy), 64'(0));
    chk("rst.idx", 64'(out_idx), 64'(0));
    chk("rst.onehot", 64'(out_onehot), 64'(0));
    req = '0;
    rst_n = 1'b1;
    step('0, 1'b0, "idle0");
    step('0, 1'b1, "idle1");
    step(8'b1010_0100, 1'b1, "pat0");
    chk("pat0.first", 64'(out_idx), 64'(7));
    step('0, 1'b1, "pat1");
    step('0, 1'b1, "pat2");
    step('0, 1'b1, "pat3");
    step(8'h01, 1'b0, "stall0");
    step(8'h80, 1'b0, "stall1");
    for (int i = 0; i < 4; i++) step('0, 1'b0, "stallh");
    chk("stall.held", 64'(out_idx), 64'(0));
    step('0, 1'b1, "stall.acc");
    chk("stall.next", 64'(out_idx), 64'(7));
    step('0, 1'b1, "stall.end");
    for (int i = 0; i < 10; i++) step(8'hFF, 1'b1, "ffheld");
    step('0, 1'b1, "drain0");
    for (int i = 0; i < 10; i++) step('0, 1'b1, "drain");
    step(8'h08, 1'b0, "rereq0");
    step(8'h08, 1'b0, "rereq1");
    step(8'h08, 1'b0, "rereq2");
    step('0, 1'b1, "rereq.acc");
    chk("rereq.again", 64'(out_idx), 64'(3));
    step('0, 1'b1, "rereq.done");
    chk("rereq.once", 64'(out_valid), 64'(0));
    for (int i = 0; i < 4; i++) step('0, 1'b1, "settle");
    step(8'h01, 1'b0, "ar0");
    step(8'h3C, 1'b0, "ar1");
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_all("areset");
    step(8'h00, 1'b1, "ar.hold");
    #2 rst_n = 1'b1;
    step('0, 1'b1, "ar.rel0");
    step('0, 1'b1, "ar.rel1");
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] r;
      r = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      step(r, 1'($urandom_range(0, 3) != 0), "rand");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
